// File: rtl/sram_ctrl.sv
// Purpose : splits each 32-bit MEM-stage load/store into two 16-bit async SRAM accesses.
// Latency : 2*ACC_CYCLES+1 cycles per access, with ready high only in the final (DONE) cycle.
// Backpr. : ready stays low while a request is pending and not yet DONE, which freezes the pipeline.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   rd_en, wr_en, address, wr_data - MEM-stage request (wr_en wins if both are set)
//   ready, rd_data, busy           - pipeline handshake, load result, FSM-active flag
//   sram_addr, sram_dq_out, sram_dq_in, sram_dq_oe, sram_we_n, sram_oe_n - SRAM pins
module sram_ctrl #(
  parameter int BASE_ADDR  = 1024,
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic        ready,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [16:0] widx;
  logic        wr_op;
  logic [15:0] wr_hi;
  logic [31:0] offset;
  logic        unused_offset_bits;

  // Word index relative to the data-memory base; addresses below the base
  // simply wrap modulo 2^17 words.
  assign offset             = address - 32'(BASE_ADDR);
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  assign ready = ~(rd_en | wr_en) | (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      widx        <= '0;
      wr_op       <= 1'b0;
      wr_hi       <= '0;
      rd_data     <= '0;
      busy        <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            state     <= LO;
            busy      <= 1'b1;
            cnt       <= '0;
            widx      <= offset[18:2];
            wr_op     <= wr_en;
            wr_hi     <= wr_data[31:16];
            sram_addr <= {offset[18:2], 1'b0};
            if (wr_en) begin
              sram_dq_out <= wr_data[15:0];
              sram_dq_oe  <= 1'b1;
              sram_we_n   <= 1'b0;
              sram_oe_n   <= 1'b1;
            end else begin
              sram_dq_oe  <= 1'b0;
              sram_we_n   <= 1'b1;
              sram_oe_n   <= 1'b0;
            end
          end
        end
        LO: begin
          if (cnt == ACC_LAST) begin
            // Strobes stay asserted across the half boundary; only the
            // address and write data move to the upper half-word.
            cnt       <= '0;
            state     <= HI;
            sram_addr <= {widx, 1'b1};
            if (wr_op) sram_dq_out   <= wr_hi;
            else       rd_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (cnt == ACC_LAST) begin
            cnt        <= '0;
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            if (!wr_op) rd_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Purpose : self-checking bench for sram_ctrl (ACC_CYCLES=2 and ACC_CYCLES=1 instances).
// Latency : each access is expected to complete in 2*ACC+1 cycles.
// Backpr. : ready is expected low until DONE while the request is held.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wr_data;
  logic        rd_en_a, wr_en_a, rd_en_b, wr_en_b;
  logic        ready_a, busy_a, dq_oe_a, we_n_a, oe_n_a;
  logic        ready_b, busy_b, dq_oe_b, we_n_b, oe_n_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [17:0] sram_addr_a, sram_addr_b;
  logic [15:0] dq_out_a, dq_in_a, dq_out_b, dq_in_b;

  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rd;
    int          rlo;
  } exp_t;
  exp_t sb[$];

  logic [31:0] last_rd [2];

  // observation mux selecting which instance the access task watches
  logic        sel;
  logic        rdy_s, busy_s, we_n_s, oe_n_s;
  logic [31:0] rd_s;
  logic [17:0] addr_s;
  assign rdy_s  = sel ? ready_b     : ready_a;
  assign busy_s = sel ? busy_b      : busy_a;
  assign we_n_s = sel ? we_n_b      : we_n_a;
  assign oe_n_s = sel ? oe_n_b      : oe_n_a;
  assign rd_s   = sel ? rd_data_b   : rd_data_a;
  assign addr_s = sel ? sram_addr_b : sram_addr_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl #(.BASE_ADDR(1024), .ACC_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en_a), .wr_en(wr_en_a),
    .address(address), .wr_data(wr_data), .ready(ready_a), .rd_data(rd_data_a),
    .busy(busy_a), .sram_addr(sram_addr_a), .sram_dq_out(dq_out_a),
    .sram_dq_in(dq_in_a), .sram_dq_oe(dq_oe_a), .sram_we_n(we_n_a), .sram_oe_n(oe_n_a)
  );

  sram_ctrl #(.BASE_ADDR(1024), .ACC_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en_b), .wr_en(wr_en_b),
    .address(address), .wr_data(wr_data), .ready(ready_b), .rd_data(rd_data_b),
    .busy(busy_b), .sram_addr(sram_addr_b), .sram_dq_out(dq_out_b),
    .sram_dq_in(dq_in_b), .sram_dq_oe(dq_oe_b), .sram_we_n(we_n_b), .sram_oe_n(oe_n_b)
  );

  // async SRAM models: combinational read, write captured while we_n is low
  assign dq_in_a = !oe_n_a ? mem_a[sram_addr_a] : 16'hFFFF;
  assign dq_in_b = !oe_n_b ? mem_b[sram_addr_b] : 16'hFFFF;
  always @(posedge clk) begin
    if (!we_n_a && dq_oe_a) mem_a[sram_addr_a] <= dq_out_a;
    if (!we_n_b && dq_oe_b) mem_b[sram_addr_b] <= dq_out_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_en(input bit s, input bit rd, input bit wr);
    if (s) begin rd_en_b = rd; wr_en_b = wr; end
    else   begin rd_en_a = rd; wr_en_a = wr; end
  endtask

  // Drives one request starting in the current cycle (called just after a
  // rising edge) and returns just after the edge that ends DONE, leaving the
  // enables as they are so the caller can issue back-to-back.
  task automatic access(input bit s, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] load_val, input int drop_at,
                        input string tag, output int start_cyc);
    int          acc;
    int          rlo, we_lo, oe_lo;
    logic [17:0] a_lo, a_hi;
    logic [31:0] off;
    exp_t        e;
    acc = s ? 1 : 2;
    off = addr - 32'd1024;
    sel = s;
    address = addr;
    wr_data = data;
    set_en(s, rd, wr);
    start_cyc = cyc;
    e.rd  = (rd && !wr) ? load_val : last_rd[s];
    e.rlo = (drop_at > 0) ? drop_at : 2 * acc + 1;
    last_rd[s] = e.rd;
    sb.push_back(e);
    rlo = 0; we_lo = 0; oe_lo = 0; a_lo = '0; a_hi = '0;
    for (int c = 0; c <= 2 * acc + 1; c++) begin
      @(negedge clk);
      if (!rdy_s)  rlo++;
      if (!we_n_s) we_lo++;
      if (!oe_n_s) oe_lo++;
      if (c == 1)       a_lo = addr_s;
      if (c == acc + 1) a_hi = addr_s;
      if (c == 2 * acc + 1) begin
        chk({tag, ".busy_done"}, 32'(busy_s), 32'd1);
        if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          chk({tag, ".rd_data"}, rd_s, e.rd);
          chk({tag, ".ready_low"}, rlo, e.rlo);
        end
      end
      @(posedge clk); #1;
      if (c + 1 == drop_at) set_en(s, 1'b0, 1'b0);
    end
    chk({tag, ".we_low"}, we_lo, wr ? 2 * acc : 0);
    chk({tag, ".oe_low"}, oe_lo, (rd && !wr) ? 2 * acc : 0);
    chk({tag, ".addr_lo"}, 32'(a_lo), 32'({off[18:2], 1'b0}));
    chk({tag, ".addr_hi"}, 32'(a_hi), 32'({off[18:2], 1'b1}));
  endtask

  task automatic idle();
    rd_en_a = 0; wr_en_a = 0; rd_en_b = 0; wr_en_b = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    sel = 0; address = 32'd1032; wr_data = 32'h0;
    rd_en_a = 0; rd_en_b = 0; wr_en_b = 0;

    // reset held two cycles with a store pending
    rst = 1; wr_en_a = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready",  32'(ready_a),   32'd0);
    chk("rst.we_n",   32'(we_n_a),    32'd1);
    chk("rst.oe_n",   32'(oe_n_a),    32'd1);
    chk("rst.dq_oe",  32'(dq_oe_a),   32'd0);
    chk("rst.rd",     rd_data_a,      32'd0);
    chk("rst.busy",   32'(busy_a),    32'd0);
    chk("rst.addr",   32'(sram_addr_a), 32'd0);
    chk("rst.dq_out", 32'(dq_out_a),  32'd0);
    chk("rst.b_we_n", 32'(we_n_b),    32'd1);
    @(posedge clk); #1;
    rst = 0; wr_en_a = 0;
    idle();

    // store / load at ACC=2
    access(0, 0, 1, 32'd1032, 32'hDEADBEEF, 32'h0, 0, "st1032", t0);
    idle();
    chk("mem_a[4]", 32'(mem_a[4]), 32'h0000BEEF);
    chk("mem_a[5]", 32'(mem_a[5]), 32'h0000DEAD);
    access(0, 1, 0, 32'd1032, 32'h0, 32'hDEADBEEF, 0, "ld1032", t0);
    idle();

    // both enables: write wins, rd_data untouched
    access(0, 1, 1, 32'd1024, 32'h12345678, 32'h0, 0, "prio", t0);
    idle();
    chk("prio.mem0", 32'(mem_a[0]), 32'h00005678);
    chk("prio.mem1", 32'(mem_a[1]), 32'h00001234);

    // enables dropped in cycle 2: operation must still finish
    access(0, 1, 1, 32'd1024, 32'h9ABCDEF0, 32'h0, 2, "drop", t0);
    idle();
    chk("drop.mem0", 32'(mem_a[0]), 32'h0000DEF0);
    chk("drop.mem1", 32'(mem_a[1]), 32'h00009ABC);
    access(0, 1, 0, 32'd1024, 32'h0, 32'h9ABCDEF0, 0, "ld1024", t0);
    idle();

    // reset during HI of a read
    sel = 0; address = 32'd1032; rd_en_a = 1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mid.partial_rd", rd_data_a, 32'h9ABCBEEF);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid.busy",  32'(busy_a),  32'd0);
    chk("mid.ready", 32'(ready_a), 32'd0);
    chk("mid.oe_n",  32'(oe_n_a),  32'd1);
    chk("mid.we_n",  32'(we_n_a),  32'd1);
    chk("mid.rd",    rd_data_a,    32'd0);
    @(posedge clk); #1;
    rst = 0; rd_en_a = 0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    idle();

    // ACC=1: wrap below base, then back-to-back loads
    access(1, 0, 1, 32'd1020, 32'hCAFEF00D, 32'h0, 0, "wrap_st", t0);
    idle();
    chk("wrap.lo", 32'(mem_b[18'h3FFFE]), 32'h0000F00D);
    chk("wrap.hi", 32'(mem_b[18'h3FFFF]), 32'h0000CAFE);
    access(1, 0, 1, 32'd1024, 32'h0BADC0DE, 32'h0, 0, "b_st1024", t0);
    idle();
    access(1, 1, 0, 32'd1020, 32'h0, 32'hCAFEF00D, 0, "b2b_ld0", t0);
    access(1, 1, 0, 32'd1024, 32'h0, 32'h0BADC0DE, 0, "b2b_ld1", t1);
    idle();
    chk("b2b.spacing", t1 - t0, 32'd4);
    chk("sb.drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Multi-cycle controller that sits between the pipeline's MEM stage and an external 16-bit asynchronous SRAM. It replaces the single-cycle data memory. Each 32-bit load or store is split into two 16-bit SRAM half-word accesses. While an access is in flight, `ready` is held low so the pipeline freezes; the MEM stage advances on the edge where `ready` is high.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address of data-memory word 0.
- `ACC_CYCLES`, default 2: cycles per half-word SRAM access (legal range 1..15).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  load request from MEM stage.
- `wr_en`  in  1  store request from MEM stage.
- `address`  in  32  byte address (ALU result).
- `wr_data`  in  32  store data (Val_Rm).
- `ready`  out  1  combinational; low = freeze pipeline.
- `rd_data`  out  32  registered load result.
- `busy`  out  1  registered; high when state ≠ IDLE.
- `sram_addr`  out  18  SRAM half-word address (registered).
- `sram_dq_out`  out  16  SRAM write data (registered).
- `sram_dq_in`  in  16  SRAM read data.
- `sram_dq_oe`  out  1  drive enable for the DQ pad; high during writes.
- `sram_we_n`  out  1  SRAM write strobe, active low.
- `sram_oe_n`  out  1  SRAM output enable, active low.

## Operation
- **States:** IDLE, LO, HI, DONE.
- **Reset:** forces IDLE. Outputs after reset:
  - `rd_data` = 0, `sram_addr` = 0, `sram_dq_out` = 0
  - `sram_dq_oe` = 0, `sram_we_n` = 1, `sram_oe_n` = 1, `busy` = 0
  - Cycle counter = 0.
- **`ready`:** `ready = ~(rd_en | wr_en) | (state == DONE)`. With no request, `ready` = 1 in any state.
- **Acceptance (IDLE):**
  - When `rd_en | wr_en` is high, latch the address, `wr_data`, and the operation type, then go to LO.
  - `wr_en` has priority if both enables are high.
- **Address mapping:**
  - `widx = (address - BASE_ADDR) >> 2`, truncated to 17 bits (modulo 2^17 words). Addresses below `BASE_ADDR` wrap; no error is flagged.
  - Low half is at `{widx, 1'b0}`; high half is at `{widx, 1'b1}`.
  - `address[1:0]` is ignored.
- **LO state:** lasts `ACC_CYCLES` cycles, driving `sram_addr = {widx, 0}`.
  - Write: `sram_we_n` = 0, `sram_dq_oe` = 1, `sram_dq_out` = `wr_data[15:0]`.
  - Read: `sram_oe_n` = 0; `sram_dq_in` is sampled into `rd_data[15:0]` on the last LO cycle.
- **HI state:** identical to LO, using `{widx, 1}` and bits [31:16].
- **DONE state:** lasts 1 cycle.
  - All SRAM strobes are deasserted (`we_n` = `oe_n` = 1, `dq_oe` = 0).
  - `ready` = 1.
  - Next state is IDLE.
- **Latched request:** once accepted, a request always runs to completion. Deasserting `rd_en`/`wr_en` mid-operation does not abort it; only `rst` aborts.
- **`rd_data` holding:** `rd_data` holds its value until the next read overwrites it. Writes never alter it. Partial update is visible: bits [15:0] change at the end of LO.
- **Same-request re-issue:** in DONE the pipeline advances. If the next instruction also accesses memory, it is accepted in the following IDLE cycle.

## Timing
- Request first visible at cycle 0 (state IDLE).
  - LO spans cycles 1..ACC.
  - HI spans cycles ACC+1..2·ACC.
  - DONE is cycle 2·ACC+1.
- `ready` is low in cycles 0..2·ACC and high in cycle 2·ACC+1. The pipeline is therefore frozen for 2·ACC+1 cycles. With ACC=2, `ready` is low for 5 cycles and high in cycle 5.
- Minimum spacing between back-to-back accesses is 2·ACC+2 cycles (one IDLE cycle between them).
- `sram_addr`/`sram_dq_out` change only at state entry. They are stable for the whole half-word window, and `we_n` rises in the same edge the window ends.
- Reset in any cycle: next cycle is IDLE with the reset values above. A write interrupted by reset may leave the SRAM half-written; this is acceptable.

## Test plan
- **Reset:** assert `rst` 2 cycles with `wr_en`=1 → `we_n`=1, `oe_n`=1, `dq_oe`=0, `rd_data`=0, `busy`=0; `ready`=0 (request pending, state IDLE).
- **Store:** ACC=2, `wr_en`, address 1032, data 0xDEADBEEF → SRAM model holds 0xBEEF at 4 and 0xDEAD at 5; `we_n` low for 2 cycles per half; `ready` low for exactly 5 cycles.
- **Load:** after the store, `rd_en` at 1032 → `rd_data`=0xDEADBEEF in the DONE cycle (cycle 5), with `ready`=1 in that cycle only.
- **Priority and abort:**
  - `rd_en`=`wr_en`=1, address 1024, data 0x12345678 → write performed, SRAM[0]=0x5678, SRAM[1]=0x1234, `rd_data` unchanged.
  - Repeat, dropping both enables in cycle 2 → operation still completes.
- **Reset mid-operation:** `rst` asserted during HI of a read → next cycle IDLE, strobes deasserted, `rd_data`=0.
- **Wrap and ACC=1:** ACC=1, address 1020 → `sram_addr` 0x3FFFE/0x3FFFF; `ready` low for 3 cycles; back-to-back loads complete every 4 cycles.
